reg_bus_arbiter: RTL and testbench
==================================

Name: reg_bus_arbiter

Overview:
Two-requester arbiter sharing the single register-bank access port between the SPI peripheral (requester 0) and the I2C peripheral (requester 1), replacing the static select mux. It arbitrates each request, latches the winner's command, and issues it to the register bank. It then waits for ack/err or a timeout and returns the response to the granted requester only.

Parameters:
ADDR_W, 8, register address width
REG_W, 8, register data width
TIMEOUT, 15, max cycles in BUSY waiting for m_ack/m_err before forced error (1..255)

Ports:
clk  input  1  clock
rstb  input  1  reset; asynchronous, active-low
ena  input  1  global enable; 0 freezes all state, counters and outputs
fixed_prio  input  1  0 = round-robin, 1 = requester 0 always wins ties
req  input  2  per-requester request level; bit0 = SPI, bit1 = I2C
wr_rdn  input  2  per-requester 1 = write, 0 = read
addr  input  2*ADDR_W  per-requester address; [ADDR_W-1:0] = req0
wdata  input  2*REG_W  per-requester write data; [REG_W-1:0] = req0
ack  output  2  one-cycle completion pulse to the granted requester
err  output  2  one-cycle error pulse to the granted requester; never coincident with ack on the same bit
rdata  output  REG_W  read data; valid in the cycle ack/err is high
gnt  output  2  one-hot current grant; 0 in IDLE
busy  output  1  high in BUSY and RESP
m_valid  output  1  command valid to register bank; held high throughout BUSY
m_wr_rdn  output  1  latched direction
m_addr  output  ADDR_W  latched address
m_wdata  output  REG_W  latched write data
m_we  output  1  one-cycle write strobe; first BUSY cycle only, and only for writes
m_rdata  input  REG_W  register bank read data
m_ack  input  1  register bank completion
m_err  input  1  register bank error

Behaviour:
- Reset: state IDLE; all outputs 0; last_gnt = 1, so requester 0 wins the first tie; timeout counter 0.
- All state and output registers update only when ena=1. With ena=0, everything holds its value, and any pulse in flight stays high until ena returns.
- States:
  - IDLE -> BUSY when req != 0.
  - BUSY -> RESP on m_ack, on m_err, or when the counter reaches TIMEOUT.
  - RESP -> IDLE unconditionally.
- IDLE, arbitration:
  - If exactly one req bit is set, that requester wins.
  - If both are set: with fixed_prio=1, requester 0 wins; with fixed_prio=0, the requester other than last_gnt wins.
  - On the IDLE->BUSY transition: latch the winner's wr_rdn, addr and wdata into the m_* registers; set gnt one-hot; update last_gnt; clear the counter.
- BUSY:
  - m_valid = 1. m_we = m_wr_rdn in the first BUSY cycle only.
  - The counter increments each cycle that neither m_ack nor m_err is high.
  - If m_ack and m_err are both high, err takes precedence.
  - Capture m_rdata into rdata on m_ack; writes also capture it. On error or timeout, rdata = 0.
- RESP:
  - m_valid = 0. Pulse ack[g] or err[g] for exactly one cycle, where g is the granted index. gnt is still valid.
  - Return to IDLE next cycle, with gnt cleared.
- Latency: req seen in IDLE at cycle N -> m_valid/m_we at N+1. If m_ack is high at N+1, ack pulses at N+2 and IDLE is reached at N+3. Minimum spacing between grants is 3 cycles.
- Inputs are sampled only at the grant edge:
  - req, addr and wdata changes during BUSY/RESP are ignored.
  - Dropping req during BUSY does not abort; the response is still pulsed.
  - A requester that keeps req high after ack is re-arbitrated, so with both requesters active, round-robin alternates 0,1,0,1.
- m_ack/m_err arriving in IDLE or RESP are ignored.
- Asynchronous reset mid-transaction returns to IDLE immediately with all outputs 0. No ack/err is generated for the aborted transfer.

Test Plan:
- Single write: req=01, wr_rdn=01, addr0=0x03, wdata0=0xA5; bank acks in the first BUSY cycle -> m_we=1 for one cycle with m_addr=0x03 and m_wdata=0xA5; ack=01 two cycles after grant; gnt=01 until IDLE.
- Single read from I2C: req=10, addr1=0x0A, m_rdata=0x5C, m_ack delayed 3 cycles -> m_we never asserted; ack=10 with rdata=0x5C; m_valid high for 4 cycles.
- Contention, round-robin: both req held high, fixed_prio=0, bank acks immediately -> grant order 0,1,0,1 over 4 transactions. Same stimulus with fixed_prio=1 -> grants 0,0,0,0.
- Timeout: TIMEOUT=15, no m_ack -> err pulse on the granted bit after 15 BUSY cycles; rdata=0; ack stays 0; next request serviced normally.
- Error precedence and stray ack: m_ack and m_err high in the same BUSY cycle -> err only. An m_ack pulse in IDLE -> no state change.
- Robustness: ena=0 during BUSY for 5 cycles -> all outputs frozen, counter held; completes normally after ena=1. rstb low mid-BUSY -> all outputs 0 immediately, no ack/err, next arbitration favours requester 0.

Source files
------------

// File: rtl/reg_bus_arbiter_if.sv
// Requester-side and register-bank-side signal bundle for the reg_bus_arbiter.
// The slave modport is the arbiter; the master modport is whatever drives it.
interface reg_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned REG_W  = 8
);
    logic                  ena;
    logic                  fixed_prio;
    logic [1:0]            req;
    logic [1:0]            wr_rdn;
    logic [2*ADDR_W-1:0]   addr;
    logic [2*REG_W-1:0]    wdata;
    logic [1:0]            ack;
    logic [1:0]            err;
    logic [REG_W-1:0]      rdata;
    logic [1:0]            gnt;
    logic                  busy;
    logic                  m_valid;
    logic                  m_wr_rdn;
    logic [ADDR_W-1:0]     m_addr;
    logic [REG_W-1:0]      m_wdata;
    logic                  m_we;
    logic [REG_W-1:0]      m_rdata;
    logic                  m_ack;
    logic                  m_err;

    modport slave (
        input  ena, fixed_prio, req, wr_rdn, addr, wdata, m_rdata, m_ack, m_err,
        output ack, err, rdata, gnt, busy, m_valid, m_wr_rdn, m_addr, m_wdata, m_we
    );

    modport master (
        output ena, fixed_prio, req, wr_rdn, addr, wdata, m_rdata, m_ack, m_err,
        input  ack, err, rdata, gnt, busy, m_valid, m_wr_rdn, m_addr, m_wdata, m_we
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Two-requester (SPI=0, I2C=1) arbiter for the single register-bank port:
// arbitrate, latch the winner's command, wait for ack/err/timeout, respond.
module reg_bus_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned REG_W   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rstb,
    reg_bus_arbiter_if.slave   bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_last, w_last_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [1:0]           r_gnt, w_gnt_nxt;
    logic [1:0]           r_ack, w_ack_nxt;
    logic [1:0]           r_err, w_err_nxt;
    logic [REG_W-1:0]     r_rdata, w_rdata_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_m_valid, w_m_valid_nxt;
    logic                 r_m_wr_rdn, w_m_wr_rdn_nxt;
    logic [ADDR_W-1:0]    r_m_addr, w_m_addr_nxt;
    logic [REG_W-1:0]     r_m_wdata, w_m_wdata_nxt;
    logic                 r_m_we, w_m_we_nxt;

    logic                 w_win;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 w_timeout;

    // Winner index: single requester wins outright; ties go to 0 (fixed) or away from last grant
    assign w_win     = (bus.req == 2'b10) ? 1'b1
                     : (bus.req == 2'b11) ? (~bus.fixed_prio & ~r_last)
                     : 1'b0;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)         r_state <= S_IDLE;
        else if (bus.ena)  r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|bus.req) w_state_nxt = S_BUSY;
            S_BUSY:  if (bus.m_ack || bus.m_err || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of all output/datapath registers; default is to hold
    always_comb begin
        w_last_nxt     = r_last;
        w_cnt_nxt      = r_cnt;
        w_gnt_nxt      = r_gnt;
        w_ack_nxt      = r_ack;
        w_err_nxt      = r_err;
        w_rdata_nxt    = r_rdata;
        w_busy_nxt     = r_busy;
        w_m_valid_nxt  = r_m_valid;
        w_m_wr_rdn_nxt = r_m_wr_rdn;
        w_m_addr_nxt   = r_m_addr;
        w_m_wdata_nxt  = r_m_wdata;
        w_m_we_nxt     = r_m_we;
        case (r_state)
            S_IDLE: begin
                if (|bus.req) begin
                    w_last_nxt     = w_win;
                    w_cnt_nxt      = '0;
                    w_gnt_nxt      = w_win ? 2'b10 : 2'b01;
                    w_busy_nxt     = 1'b1;
                    w_m_valid_nxt  = 1'b1;
                    w_m_wr_rdn_nxt = bus.wr_rdn[w_win];
                    w_m_we_nxt     = bus.wr_rdn[w_win];
                    w_m_addr_nxt   = w_win ? bus.addr[2*ADDR_W-1:ADDR_W] : bus.addr[ADDR_W-1:0];
                    w_m_wdata_nxt  = w_win ? bus.wdata[2*REG_W-1:REG_W] : bus.wdata[REG_W-1:0];
                end
            end
            S_BUSY: begin
                w_m_we_nxt = 1'b0;
                if (bus.m_err) begin
                    w_err_nxt     = r_gnt;
                    w_rdata_nxt   = '0;
                    w_m_valid_nxt = 1'b0;
                end else if (bus.m_ack) begin
                    w_ack_nxt     = r_gnt;
                    w_rdata_nxt   = bus.m_rdata;
                    w_m_valid_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_timeout) begin
                        w_err_nxt     = r_gnt;
                        w_rdata_nxt   = '0;
                        w_m_valid_nxt = 1'b0;
                    end
                end
            end
            S_RESP: begin
                w_ack_nxt   = 2'b00;
                w_err_nxt   = 2'b00;
                w_gnt_nxt   = 2'b00;
                w_busy_nxt  = 1'b0;
                w_rdata_nxt = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_last     <= 1'b1;
            r_cnt      <= '0;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_err      <= '0;
            r_rdata    <= '0;
            r_busy     <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_wr_rdn <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_m_we     <= 1'b0;
        end else if (bus.ena) begin
            r_last     <= w_last_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gnt      <= w_gnt_nxt;
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
            r_rdata    <= w_rdata_nxt;
            r_busy     <= w_busy_nxt;
            r_m_valid  <= w_m_valid_nxt;
            r_m_wr_rdn <= w_m_wr_rdn_nxt;
            r_m_addr   <= w_m_addr_nxt;
            r_m_wdata  <= w_m_wdata_nxt;
            r_m_we     <= w_m_we_nxt;
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.ack      = r_ack;
    assign bus.err      = r_err;
    assign bus.rdata    = r_rdata;
    assign bus.busy     = r_busy;
    assign bus.m_valid  = r_m_valid;
    assign bus.m_wr_rdn = r_m_wr_rdn;
    assign bus.m_addr   = r_m_addr;
    assign bus.m_wdata  = r_m_wdata;
    assign bus.m_we     = r_m_we;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration/response model.
module tb_reg_bus_arbiter;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned REG_W   = 8;
    localparam int unsigned TIMEOUT = 15;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_last = 1;   // model: index of the most recent grant

    reg_bus_arbiter_if #(.ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

    reg_bus_arbiter #(.ADDR_W(ADDR_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [1:0] r, input logic fp, input int last);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        if (fp) return 0;
        return 1 - last;
    endfunction

    function automatic logic [1:0] oh(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic test_reset();
        bus.ena = 1'b1; bus.fixed_prio = 1'b0; bus.req = 2'b00; bus.wr_rdn = 2'b00;
        bus.addr = '0; bus.wdata = '0; bus.m_rdata = '0; bus.m_ack = 1'b0; bus.m_err = 1'b0;
        rstb = 1'b0;
        step(); step();
        n_chk++; if ({bus.ack, bus.err, bus.rdata, bus.gnt, bus.busy, bus.m_valid, bus.m_wr_rdn,
                     bus.m_addr, bus.m_wdata, bus.m_we} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got gnt=%b busy=%b m_valid=%b m_addr=%h exp all 0",
                               bus.gnt, bus.busy, bus.m_valid, bus.m_addr);
        end
        rstb = 1'b1; m_last = 1;
        step();
        n_chk++; if ({bus.gnt, bus.busy, bus.m_valid, bus.ack, bus.err} !== '0) begin
            n_fail++; $display("FAIL reset_idle: got gnt=%b busy=%b m_valid=%b exp 0", bus.gnt, bus.busy, bus.m_valid);
        end
    endtask

    task automatic test_single_write();
        m_last = pick(2'b01, 1'b0, m_last);
        bus.req = 2'b01; bus.wr_rdn = 2'b01; bus.addr = 16'h7703; bus.wdata = 16'h11A5;
        step();
        n_chk++; if ({bus.m_valid, bus.m_we, bus.m_wr_rdn} !== 3'b111) begin
            n_fail++; $display("FAIL wr_strobe: got valid/we/dir=%b exp 111", {bus.m_valid, bus.m_we, bus.m_wr_rdn});
        end
        n_chk++; if ({bus.m_addr, bus.m_wdata} !== 16'h03A5) begin
            n_fail++; $display("FAIL wr_cmd: got addr=%h wdata=%h exp 03 A5", bus.m_addr, bus.m_wdata);
        end
        n_chk++; if (bus.gnt !== 2'b01) begin
            n_fail++; $display("FAIL wr_gnt: got %b exp 01", bus.gnt);
        end
        bus.req = 2'b00; bus.addr = 16'hFFFF; bus.m_ack = 1'b1; bus.m_rdata = 8'h42;
        step();
        bus.m_ack = 1'b0;
        n_chk++; if ({bus.ack, bus.err} !== 4'b0100) begin
            n_fail++; $display("FAIL wr_ack: got ack=%b err=%b exp 01 00", bus.ack, bus.err);
        end
        n_chk++; if ({bus.m_valid, bus.m_we, bus.busy, bus.gnt} !== 5'b00101) begin
            n_fail++; $display("FAIL wr_resp_state: got valid=%b we=%b busy=%b gnt=%b exp 0 0 1 01",
                               bus.m_valid, bus.m_we, bus.busy, bus.gnt);
        end
        step();
        n_chk++; if ({bus.gnt, bus.busy, bus.ack, bus.err} !== '0) begin
            n_fail++; $display("FAIL wr_idle: got gnt=%b busy=%b ack=%b exp 0", bus.gnt, bus.busy, bus.ack);
        end
    endtask

    task automatic test_single_read();
        int mv;
        logic we_seen;
        m_last = pick(2'b10, 1'b0, m_last);
        bus.req = 2'b10; bus.wr_rdn = 2'b00; bus.addr = 16'h0A55;
        step();
        n_chk++; if ({bus.gnt, bus.m_addr} !== {2'b10, 8'h0A}) begin
            n_fail++; $display("FAIL rd_grant: got gnt=%b addr=%h exp 10 0A", bus.gnt, bus.m_addr);
        end
        bus.req = 2'b00;
        mv = (bus.m_valid === 1'b1) ? 1 : 0;
        we_seen = bus.m_we;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.m_valid === 1'b1) mv++;
            we_seen |= bus.m_we;
        end
        bus.m_ack = 1'b1; bus.m_rdata = 8'h5C;
        step();
        bus.m_ack = 1'b0;
        n_chk++; if ({bus.ack, bus.err, bus.rdata} !== {2'b10, 2'b00, 8'h5C}) begin
            n_fail++; $display("FAIL rd_resp: got ack=%b err=%b rdata=%h exp 10 00 5C", bus.ack, bus.err, bus.rdata);
        end
        n_chk++; if (mv !== 4 || we_seen !== 1'b0) begin
            n_fail++; $display("FAIL rd_valid_len: got valid cycles=%0d we_seen=%b exp 4 0", mv, we_seen);
        end
        step();
    endtask

    task automatic test_contention(input logic fp);
        logic [1:0] seen[$];
        int w;
        bus.fixed_prio = fp; bus.req = 2'b11; bus.wr_rdn = 2'($urandom); bus.m_ack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.m_valid === 1'b1) seen.push_back(bus.gnt);
        end
        bus.req = 2'b00; bus.m_ack = 1'b0;
        step();
        n_chk++; if (seen.size() != 4) begin
            n_fail++; $display("FAIL contention_count fp=%b: got %0d grants exp 4", fp, seen.size());
        end
        for (int k = 0; k < seen.size() && k < 4; k++) begin
            w = pick(2'b11, fp, m_last);
            m_last = w;
            n_chk++; if (seen[k] !== oh(w)) begin
                n_fail++; $display("FAIL contention_order fp=%b #%0d: got gnt=%b exp %b", fp, k, seen[k], oh(w));
            end
        end
        bus.fixed_prio = 1'b0;
    endtask

    task automatic test_timeout();
        int mv;
        m_last = pick(2'b01, 1'b0, m_last);
        bus.req = 2'b01; bus.wr_rdn = 2'b00; bus.addr = 16'($urandom);
        step();
        bus.req = 2'b00; bus.m_rdata = 8'hFF;
        mv = 0;
        while (bus.m_valid === 1'b1 && mv < 40) begin
            mv++;
            step();
        end
        n_chk++; if (mv != TIMEOUT) begin
            n_fail++; $display("FAIL timeout_len: got %0d busy cycles exp %0d", mv, TIMEOUT);
        end
        n_chk++; if ({bus.ack, bus.err, bus.rdata} !== {2'b00, 2'b01, 8'h00}) begin
            n_fail++; $display("FAIL timeout_resp: got ack=%b err=%b rdata=%h exp 00 01 00", bus.ack, bus.err, bus.rdata);
        end
        step();
        m_last = pick(2'b10, 1'b0, m_last);
        bus.req = 2'b10;
        step();
        bus.req = 2'b00; bus.m_ack = 1'b1; bus.m_rdata = 8'h3C;
        step();
        bus.m_ack = 1'b0;
        n_chk++; if ({bus.ack, bus.err, bus.rdata} !== {2'b10, 2'b00, 8'h3C}) begin
            n_fail++; $display("FAIL after_timeout: got ack=%b err=%b rdata=%h exp 10 00 3C", bus.ack, bus.err, bus.rdata);
        end
        step();
    endtask

    task automatic test_err_prec();
        m_last = pick(2'b01, 1'b0, m_last);
        bus.req = 2'b01; bus.wr_rdn = 2'b01;
        step();
        bus.req = 2'b00; bus.m_ack = 1'b1; bus.m_err = 1'b1; bus.m_rdata = 8'h77;
        step();
        bus.m_ack = 1'b0; bus.m_err = 1'b0;
        n_chk++; if ({bus.ack, bus.err, bus.rdata} !== {2'b00, 2'b01, 8'h00}) begin
            n_fail++; $display("FAIL err_prec: got ack=%b err=%b rdata=%h exp 00 01 00", bus.ack, bus.err, bus.rdata);
        end
        step();
        bus.m_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_chk++; if ({bus.busy, bus.gnt, bus.m_valid, bus.ack, bus.err} !== '0) begin
                n_fail++; $display("FAIL stray_ack #%0d: got busy=%b gnt=%b ack=%b exp 0", i, bus.busy, bus.gnt, bus.ack);
            end
        end
        bus.m_ack = 1'b0;
    endtask

    task automatic test_ena();
        int mv;
        m_last = pick(2'b10, 1'b0, m_last);
        bus.req = 2'b10; bus.wr_rdn = 2'b10; bus.addr = 16'h2100;
        step();
        bus.ena = 1'b0; bus.req = 2'b00; bus.m_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++; if ({bus.gnt, bus.busy, bus.m_valid, bus.m_we, bus.ack, bus.err, bus.m_addr} !==
                         {2'b10, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 8'h21}) begin
                n_fail++; $display("FAIL ena_freeze #%0d: got gnt=%b busy=%b valid=%b we=%b ack=%b addr=%h exp 10 1 1 1 00 21",
                                   i, bus.gnt, bus.busy, bus.m_valid, bus.m_we, bus.ack, bus.m_addr);
            end
        end
        bus.ena = 1'b1; bus.m_ack = 1'b0;
        mv = 0;
        while (bus.m_valid === 1'b1 && mv < 40) begin
            mv++;
            step();
        end
        n_chk++; if (mv != TIMEOUT || bus.err !== 2'b10) begin
            n_fail++; $display("FAIL ena_resume: got %0d busy cycles err=%b exp %0d 10", mv, bus.err, TIMEOUT);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int w;
        m_last = pick(2'b01, 1'b0, m_last);
        bus.req = 2'b01; bus.wr_rdn = 2'b01;
        step(); step();
        rstb = 1'b0;
        #1;
        n_chk++; if ({bus.ack, bus.err, bus.gnt, bus.busy, bus.m_valid, bus.m_we, bus.m_addr, bus.m_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_mid_async: got gnt=%b busy=%b valid=%b exp 0", bus.gnt, bus.busy, bus.m_valid);
        end
        bus.req = 2'b00;
        step();
        n_chk++; if ({bus.ack, bus.err, bus.busy} !== '0) begin
            n_fail++; $display("FAIL reset_mid_hold: got ack=%b err=%b busy=%b exp 0", bus.ack, bus.err, bus.busy);
        end
        rstb = 1'b1; m_last = 1;
        w = pick(2'b11, 1'b0, m_last); m_last = w;
        bus.req = 2'b11; bus.fixed_prio = 1'b0;
        step();
        n_chk++; if (bus.gnt !== oh(w)) begin
            n_fail++; $display("FAIL reset_mid_prio: got gnt=%b exp %b", bus.gnt, oh(w));
        end
        bus.req = 2'b00; bus.m_ack = 1'b1;
        step();
        bus.m_ack = 1'b0;
        n_chk++; if ({bus.ack, bus.err} !== {oh(w), 2'b00}) begin
            n_fail++; $display("FAIL reset_mid_next: got ack=%b err=%b exp %b 00", bus.ack, bus.err, oh(w));
        end
        step();
    endtask

    task automatic test_random(input int n);
        logic [1:0]  r, wr, eack, eerr;
        logic        fp;
        logic [15:0] a, wd;
        logic [7:0]  ea, ewd, rd, erd;
        int          w, d, kind, resp_i;
        for (int t = 0; t < n; t++) begin
            r = 2'($urandom_range(1, 3)); fp = 1'($urandom); wr = 2'($urandom);
            a = 16'($urandom); wd = 16'($urandom);
            d = $urandom_range(0, TIMEOUT + 1); kind = $urandom_range(0, 3);
            w = pick(r, fp, m_last); m_last = w;
            ea  = (w == 1) ? a[15:8]  : a[7:0];
            ewd = (w == 1) ? wd[15:8] : wd[7:0];
            bus.req = r; bus.fixed_prio = fp; bus.wr_rdn = wr; bus.addr = a; bus.wdata = wd;
            step();
            n_chk++; if ({bus.gnt, bus.m_valid, bus.m_we, bus.m_wr_rdn, bus.m_addr, bus.m_wdata} !==
                         {oh(w), 1'b1, wr[w], wr[w], ea, ewd}) begin
                n_fail++; $display("FAIL rnd_grant t=%0d: got gnt=%b we=%b addr=%h wdata=%h exp %b %b %h %h",
                                   t, bus.gnt, bus.m_we, bus.m_addr, bus.m_wdata, oh(w), wr[w], ea, ewd);
            end
            resp_i = (d < int'(TIMEOUT)) ? d + 1 : int'(TIMEOUT);
            eack = 2'b00; eerr = 2'b00; erd = 8'h00; rd = 8'h00;
            for (int i = 1; i <= resp_i; i++) begin
                bus.req = 2'($urandom); bus.addr = 16'($urandom); bus.m_rdata = 8'($urandom);
                if (i == d + 1) begin
                    rd = 8'($urandom); bus.m_rdata = rd;
                    bus.m_ack = (kind != 2); bus.m_err = (kind >= 2);
                end
                step();
                bus.m_ack = 1'b0; bus.m_err = 1'b0;
                if (i < resp_i) begin
                    n_chk++; if ({bus.m_valid, bus.m_we, bus.ack, bus.err} !== 6'b100000) begin
                        n_fail++; $display("FAIL rnd_busy t=%0d i=%0d: got valid=%b we=%b ack=%b err=%b exp 1 0 00 00",
                                           t, i, bus.m_valid, bus.m_we, bus.ack, bus.err);
                    end
                end
            end
            if (d < int'(TIMEOUT) && kind < 2) begin eack = oh(w); erd = rd; end
            else eerr = oh(w);
            n_chk++; if ({bus.ack, bus.err, bus.rdata, bus.gnt, bus.m_valid} !== {eack, eerr, erd, oh(w), 1'b0}) begin
                n_fail++; $display("FAIL rnd_resp t=%0d: got ack=%b err=%b rdata=%h gnt=%b exp %b %b %h %b",
                                   t, bus.ack, bus.err, bus.rdata, bus.gnt, eack, eerr, erd, oh(w));
            end
            step();
            n_chk++; if ({bus.gnt, bus.busy, bus.ack, bus.err} !== '0) begin
                n_fail++; $display("FAIL rnd_idle t=%0d: got gnt=%b busy=%b exp 0", t, bus.gnt, bus.busy);
            end
        end
        bus.req = 2'b00; bus.fixed_prio = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention(1'b0);
        test_contention(1'b1);
        test_timeout();
        test_err_prec();
        test_ena();
        test_reset_mid();
        test_random(40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
